// File: rtl/pusch_pkg.sv
// Shared types for the PUSCH symbol scheduler: FSM states, error codes, slot geometry.
package pusch_pkg;

  localparam int unsigned NUM_SYM_DEF = 14;
  localparam int unsigned SYM_IDX_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_WAIT_FFT  = 3'd2,
    ST_WAIT_IFFT = 3'd3,
    ST_WAIT_REM  = 3'd4,
    ST_NEXT      = 3'd5,
    ST_DONE      = 3'd6
  } sched_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CONFIG  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

endpackage

// File: rtl/pusch_sched_wdog.sv
// Handshake watchdog: counts cycles spent in one wait state and flags expiry on
// the TIMEOUT_CYC-th cycle. Only used when PUSCH_SCHED_TIMEOUT_EN is defined.
module pusch_sched_wdog #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic restart_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_eff;

  // First cycle of a new wait state counts from zero regardless of history.
  assign cnt_eff   = restart_i ? '0 : cnt_q;
  assign expired_o = active_i && (cnt_eff == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (active_i) begin
      cnt_q <= cnt_eff + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/pusch_sym_sched.sv
// PUSCH per-slot symbol scheduler: sequences transform precoder, IFFT buffer and RE mapper
// per symbol. Optional handshake timeout under macro PUSCH_SCHED_TIMEOUT_EN.
module pusch_sym_sched
  import pusch_pkg::*;
#(
  parameter int unsigned NUM_SYM     = NUM_SYM_DEF,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               slot_start,
  input  logic [3:0]         sym_start,
  input  logic [3:0]         sym_end,
  input  logic [NUM_SYM-1:0] dmrs_map,
  input  logic               fft_done,
  input  logic               rem_done,
  input  logic               ifft_ready,
  output logic               fft_start,
  output logic               rem_start,
  output logic [3:0]         sym_idx,
  output logic               sym_is_dmrs,
  output logic               busy,
  output logic               slot_done,
  output logic               err,
  output logic [1:0]         err_code
);

  sched_state_e           state_q;
  logic [SYM_IDX_W-1:0]   start_q;
  logic [SYM_IDX_W-1:0]   end_q;
  logic [NUM_SYM-1:0]     map_q;
  logic [SYM_IDX_W-1:0]   sym_idx_q;
  logic                   dmrs_q;
  logic                   fft_start_q;
  logic                   busy_q;
  logic                   slot_done_q;
  logic                   err_q;
  err_code_e              err_code_q;

  logic                   cfg_bad;
  logic                   last_sym;
  logic [SYM_IDX_W-1:0]   sym_nxt;
  logic                   wd_expired;

  // Out-of-range indices read as data symbols; they are rejected in CHECK anyway.
  function automatic logic dmrs_at(input logic [NUM_SYM-1:0] map,
                                   input logic [SYM_IDX_W-1:0] idx);
    dmrs_at = 1'b0;
    for (int k = 0; k < NUM_SYM; k++) begin
      if (idx == SYM_IDX_W'(k)) dmrs_at = map[k];
    end
  endfunction

  assign cfg_bad  = (start_q > end_q) || (32'(end_q) >= NUM_SYM);
  assign last_sym = (sym_idx_q == end_q) || (32'(sym_idx_q) >= NUM_SYM - 1);
  assign sym_nxt  = sym_idx_q + SYM_IDX_W'(1);

`ifdef PUSCH_SCHED_TIMEOUT_EN
  sched_state_e prev_state_q;
  logic         wd_active;

  always_ff @(posedge clk) begin
    if (reset) prev_state_q <= ST_IDLE;
    else       prev_state_q <= state_q;
  end

  assign wd_active = (state_q == ST_WAIT_FFT) || (state_q == ST_WAIT_IFFT) ||
                     (state_q == ST_WAIT_REM);

  pusch_sched_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .active_i  (wd_active),
    .restart_i (state_q != prev_state_q),
    .expired_o (wd_expired)
  );
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign wd_expired         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      start_q     <= '0;
      end_q       <= '0;
      map_q       <= '0;
      sym_idx_q   <= '0;
      dmrs_q      <= 1'b0;
      fft_start_q <= 1'b0;
      busy_q      <= 1'b0;
      slot_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      fft_start_q <= 1'b0;
      slot_done_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (slot_start) begin
            start_q    <= sym_start;
            end_q      <= sym_end;
            map_q      <= dmrs_map;
            sym_idx_q  <= sym_start;
            dmrs_q     <= dmrs_at(dmrs_map, sym_start);
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b1;
            state_q    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (cfg_bad) begin
            err_code_q  <= ERR_CONFIG;
            err_q       <= 1'b1;
            slot_done_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (dmrs_q) begin
            state_q <= ST_WAIT_IFFT;
          end else begin
            fft_start_q <= 1'b1;
            state_q     <= ST_WAIT_FFT;
          end
        end
        ST_WAIT_FFT: begin
          if (fft_done) begin
            state_q <= ST_WAIT_IFFT;
          end else if (wd_expired) begin
            err_code_q  <= ERR_TIMEOUT;
            err_q       <= 1'b1;
            slot_done_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_WAIT_IFFT: begin
          if (ifft_ready) begin
            state_q <= ST_WAIT_REM;
          end else if (wd_expired) begin
            err_code_q  <= ERR_TIMEOUT;
            err_q       <= 1'b1;
            slot_done_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_WAIT_REM: begin
          if (rem_done) begin
            state_q <= ST_NEXT;
          end else if (wd_expired) begin
            err_code_q  <= ERR_TIMEOUT;
            err_q       <= 1'b1;
            slot_done_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_NEXT: begin
          if (last_sym) begin
            slot_done_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            sym_idx_q <= sym_nxt;
            dmrs_q    <= dmrs_at(map_q, sym_nxt);
            state_q   <= ST_CHECK;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          dmrs_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // rem_start must coincide with the ifft_ready cycle, so it is decoded, not registered.
  assign rem_start   = (state_q == ST_WAIT_IFFT) && ifft_ready;
  assign fft_start   = fft_start_q;
  assign sym_idx     = sym_idx_q;
  assign sym_is_dmrs = dmrs_q;
  assign busy        = busy_q;
  assign slot_done   = slot_done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_pusch_sym_sched.sv
// Directed self-checking bench for pusch_sym_sched; the timeout scenario runs when
// PUSCH_SCHED_TIMEOUT_EN is defined, otherwise the indefinite-wait behaviour is checked.
module tb_pusch_sym_sched;

  localparam int unsigned NSYM = 14;
  localparam int unsigned TO   = 16;
`ifdef PUSCH_SCHED_TIMEOUT_EN
  localparam int IFFT_HOLD = 10;
`else
  localparam int IFFT_HOLD = 50;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            slot_start;
  logic [3:0]      sym_start;
  logic [3:0]      sym_end;
  logic [NSYM-1:0] dmrs_map;
  logic            fft_done;
  logic            rem_done;
  logic            ifft_ready;
  logic            fft_start;
  logic            rem_start;
  logic [3:0]      sym_idx;
  logic            sym_is_dmrs;
  logic            busy;
  logic            slot_done;
  logic            err;
  logic [1:0]      err_code;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_fft = 0, cnt_rem = 0, cnt_fft_idx2 = 0, cnt_done = 0, cnt_err = 0;
  int f0, r0, d0, e0, i0;

  pusch_sym_sched #(
    .NUM_SYM     (NSYM),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .slot_start  (slot_start),
    .sym_start   (sym_start),
    .sym_end     (sym_end),
    .dmrs_map    (dmrs_map),
    .fft_done    (fft_done),
    .rem_done    (rem_done),
    .ifft_ready  (ifft_ready),
    .fft_start   (fft_start),
    .rem_start   (rem_start),
    .sym_idx     (sym_idx),
    .sym_is_dmrs (sym_is_dmrs),
    .busy        (busy),
    .slot_done   (slot_done),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled with the pre-edge values.
  always @(posedge clk) begin
    if (fft_start) cnt_fft++;
    if (rem_start) cnt_rem++;
    if (fft_start && sym_idx == 4'd2) cnt_fft_idx2++;
    if (slot_done) cnt_done++;
    if (err) cnt_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    f0 = cnt_fft; r0 = cnt_rem; d0 = cnt_done; e0 = cnt_err; i0 = cnt_fft_idx2;
  endtask

  // Returns at the first negedge after the accepting edge (state CHECK).
  task automatic start_slot(input logic [3:0] s, input logic [3:0] e, input logic [NSYM-1:0] m);
    @(negedge clk);
    sym_start  = s;
    sym_end    = e;
    dmrs_map   = m;
    slot_start = 1'b1;
    @(negedge clk);
    slot_start = 1'b0;
  endtask

  task automatic wait_slot_done(input string tag, input int max_cyc);
    int seen;
    seen = 0;
    for (int i = 0; i < max_cyc && seen == 0; i++) begin
      @(negedge clk);
      if (slot_done) seen = 1;
    end
    check(tag, seen, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_idx"}, sym_idx, 0);
    check({tag, "_dmrs"}, sym_is_dmrs, 0);
    check({tag, "_fft"}, fft_start, 0);
    check({tag, "_rem"}, rem_start, 0);
    check({tag, "_sdone"}, slot_done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_code"}, err_code, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int found;
    reset = 1'b1; slot_start = 1'b0; sym_start = '0; sym_end = '0; dmrs_map = '0;
    fft_done = 1'b0; rem_done = 1'b0; ifft_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Full slot 0..13, DMRS on symbol 2, all handshakes immediate.
    fft_done = 1'b1; rem_done = 1'b1; ifft_ready = 1'b1;
    snap();
    start_slot(4'd0, 4'd13, 14'h0004);
    check("t1_busy", busy, 1);
    check("t1_fft_c1", fft_start, 0);
    @(negedge clk);
    check("t1_fft_c2", fft_start, 1);
    wait_slot_done("t1_done_seen", 200);
    @(negedge clk);
    check("t1_fft_cnt", cnt_fft - f0, 13);
    check("t1_rem_cnt", cnt_rem - r0, 14);
    check("t1_fft_idx2", cnt_fft_idx2 - i0, 0);
    check("t1_done_cnt", cnt_done - d0, 1);
    check("t1_err_cnt", cnt_err - e0, 0);
    check("t1_code", err_code, 0);
    check("t1_idle", busy, 0);

    // Config error: start > end.
    snap();
    start_slot(4'd5, 4'd3, 14'h0000);
    wait_slot_done("t2_done_seen", 10);
    check("t2_err", err, 1);
    check("t2_code", err_code, 1);
    @(negedge clk);
    check("t2_idle", busy, 0);
    check("t2_fft_cnt", cnt_fft - f0, 0);
    check("t2_rem_cnt", cnt_rem - r0, 0);
    check("t2_done_cnt", cnt_done - d0, 1);
    check("t2_err_cnt", cnt_err - e0, 1);
    repeat (5) @(negedge clk);
    check("t2_code_hold", err_code, 1);

    // Config error: end beyond the slot.
    snap();
    start_slot(4'd0, 4'd14, 14'h0000);
    wait_slot_done("t2b_done_seen", 10);
    check("t2b_code", err_code, 1);
    check("t2b_fft_cnt", cnt_fft - f0, 0);

    // IFFT backpressure on a single-symbol slot.
    ifft_ready = 1'b0;
    snap();
    start_slot(4'd4, 4'd4, 14'h0000);
    check("t3_code_clr", err_code, 0);
    check("t3_idx", sym_idx, 4);
    @(negedge clk);
    check("t3_fft", fft_start, 1);
    repeat (IFFT_HOLD) @(negedge clk);
    check("t3_rem_held", cnt_rem - r0, 0);
    check("t3_rem_low", rem_start, 0);
    check("t3_busy", busy, 1);
    ifft_ready = 1'b1;
    #1;
    check("t3_rem_same_cycle", rem_start, 1);
    @(negedge clk);
    check("t3_rem_one_cycle", rem_start, 0);
    wait_slot_done("t3_done_seen", 20);
    @(negedge clk);
    check("t3_rem_cnt", cnt_rem - r0, 1);
    check("t3_fft_cnt", cnt_fft - f0, 1);

`ifdef PUSCH_SCHED_TIMEOUT_EN
    // fft_done never arrives: expiry after TO cycles in WAIT_FFT.
    fft_done = 1'b0;
    snap();
    start_slot(4'd0, 4'd0, 14'h0000);
    @(negedge clk);
    check("t4_fft", fft_start, 1);
    repeat (TO - 1) @(negedge clk);
    check("t4_no_early_err", err, 0);
    @(negedge clk);
    check("t4_err", err, 1);
    check("t4_code", err_code, 2);
    check("t4_sdone", slot_done, 1);
    @(negedge clk);
    check("t4_idle", busy, 0);
    check("t4_rem_cnt", cnt_rem - r0, 0);
    fft_done = 1'b1;
`else
    // Without the watchdog the scheduler waits indefinitely.
    fft_done = 1'b0;
    snap();
    start_slot(4'd0, 4'd0, 14'h0000);
    @(negedge clk);
    check("t4_fft", fft_start, 1);
    repeat (40) @(negedge clk);
    check("t4_still_busy", busy, 1);
    check("t4_code", err_code, 0);
    check("t4_err_cnt", cnt_err - e0, 0);
    fft_done = 1'b1;
    wait_slot_done("t4_done_seen", 20);
    check("t4_code_end", err_code, 0);
`endif

    // Reset while waiting for the RE mapper on DMRS symbol 7.
    snap();
    start_slot(4'd5, 4'd9, 14'h0080);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (sym_idx == 4'd7) begin
        rem_done = 1'b0;
        found = 1;
      end
    end
    check("t5_reach7", found, 1);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (rem_start) found = 1;
    end
    check("t5_rem7", found, 1);
    @(negedge clk);
    check("t5_idx7", sym_idx, 7);
    check("t5_dmrs7", sym_is_dmrs, 1);
    check("t5_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    reset = 1'b0;
    rem_done = 1'b1;
    snap();
    start_slot(4'd2, 4'd3, 14'h0008);
    wait_slot_done("t5_after_done", 50);
    @(negedge clk);
    check("t5_fft_cnt", cnt_fft - f0, 1);
    check("t5_rem_cnt", cnt_rem - r0, 2);
    check("t5_done_cnt", cnt_done - d0, 1);
    check("t5_code", err_code, 0);

    // slot_start while busy and stray rem_done during WAIT_FFT.
    fft_done = 1'b0;
    snap();
    start_slot(4'd1, 4'd2, 14'h0000);
    @(negedge clk);
    check("t6_fft", fft_start, 1);
    sym_start  = 4'd9;
    sym_end    = 4'd9;
    slot_start = 1'b1;
    @(negedge clk);
    slot_start = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_idx", sym_idx, 1);
    check("t6_busy", busy, 1);
    check("t6_rem_cnt", cnt_rem - r0, 0);
    check("t6_fft_cnt", cnt_fft - f0, 1);
    fft_done = 1'b1;
    wait_slot_done("t6_done_seen", 50);
    @(negedge clk);
    check("t6_fft_total", cnt_fft - f0, 2);
    check("t6_rem_total", cnt_rem - r0, 2);
    check("t6_done_cnt", cnt_done - d0, 1);
    check("t6_code", err_code, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pusch_sym_sched.md
PUSCH_SYM_SCHED -- requirements
Module: pusch_sym_sched

Interface
REQ-001 SHALL have parameter NUM_SYM, default 14, meaning OFDM symbols per slot.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096, meaning maximum wait cycles per handshake.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port slot_start, input, 1 bit: one-cycle pulse that starts a slot.
REQ-006 SHALL have ports sym_start and sym_end, input, 4 bits each: first and last allocated symbol.
REQ-007 SHALL have port dmrs_map, input, NUM_SYM bits: bit k=1 marks symbol k as DMRS.
REQ-008 SHALL have port fft_done, input, 1 bit: transform-precoder finished the current symbol.
REQ-009 SHALL have port rem_done, input, 1 bit: resource element mapper finished the current symbol.
REQ-010 SHALL have port ifft_ready, input, 1 bit: IFFT ping-pong buffer can accept a symbol.
REQ-011 SHALL have outputs fft_start and rem_start, 1 bit each: one-cycle start pulses.
REQ-012 SHALL have outputs sym_idx (4 bits) and sym_is_dmrs (1 bit): current symbol and its type.
REQ-013 SHALL have outputs busy, slot_done and err, 1 bit each; err_code is a 2-bit output (0 none, 1 config, 2 timeout).

Function
REQ-014 SHALL implement states IDLE, CHECK, WAIT_FFT, WAIT_IFFT, WAIT_REM, NEXT, DONE.
REQ-015 SHALL, in IDLE on slot_start, register sym_start, sym_end and dmrs_map, set sym_idx=sym_start, and go to CHECK.
REQ-016 SHALL, in CHECK with sym_start>sym_end or sym_end>=NUM_SYM, set err_code=1, pulse err, and go to DONE without issuing any start.
REQ-017 SHALL, in CHECK for a data symbol (dmrs bit 0), pulse fft_start for one cycle and go to WAIT_FFT; the first fft_start is at cycle 2 after slot_start.
REQ-018 SHALL, in CHECK for a DMRS symbol, go directly to WAIT_IFFT and never pulse fft_start.
REQ-019 SHALL, in WAIT_FFT, go to WAIT_IFFT on fft_done.
REQ-020 SHALL, in WAIT_IFFT, pulse rem_start for one cycle in the same cycle ifft_ready=1, then go to WAIT_REM; rem_start stays low while ifft_ready=0.
REQ-021 SHALL, in WAIT_REM, go to NEXT on rem_done.
REQ-022 SHALL, in NEXT, go to DONE if sym_idx==sym_end; otherwise increment sym_idx and go to CHECK. sym_idx never wraps past NUM_SYM-1.
REQ-023 SHALL, in DONE, pulse slot_done for one cycle and return to IDLE.
REQ-024 SHALL hold sym_is_dmrs equal to the registered dmrs_map[sym_idx] during all active states.
REQ-025 SHALL assert busy in every state except IDLE.
REQ-026 SHALL ignore slot_start while busy.
REQ-027 SHALL ignore a done input outside its matching wait state; fft_done and rem_done asserted together are therefore resolved by state alone.
REQ-028 SHALL keep a symbol with sym_start==sym_end as a one-symbol slot.

Reset
REQ-029 SHALL, on reset=1 at a clock edge (including mid-slot), force state IDLE and sym_idx=0, deassert sym_is_dmrs, fft_start, rem_start, busy, slot_done and err, set err_code=0, and clear the timeout counter.
REQ-030 SHALL keep err_code until the next accepted slot_start or reset.

Configuration
REQ-031 SHALL, with macro PUSCH_SCHED_TIMEOUT_EN defined, count cycles in WAIT_FFT, WAIT_IFFT and WAIT_REM, resetting the count on each state entry.
REQ-032 SHALL, with PUSCH_SCHED_TIMEOUT_EN defined and the count reaching TIMEOUT_CYC, set err_code=2, pulse err, and go to DONE.
REQ-033 SHALL, without PUSCH_SCHED_TIMEOUT_EN, omit the counter and wait indefinitely; err_code=2 never occurs.

Structure
REQ-034 SHALL place the state enumeration, the err_code values and the NUM_SYM default in the shared package pusch_pkg.
REQ-035 SHALL contain one sub-module, pusch_sched_wdog (timeout counter), instantiated only when PUSCH_SCHED_TIMEOUT_EN is defined.

Verification
REQ-036 Bench SHALL check sym_start=0, sym_end=13, dmrs_map=14'h0004, immediate dones -> 13 fft_start pulses, 14 rem_start pulses, no fft_start at sym_idx=2, one slot_done.
REQ-037 Bench SHALL check sym_start=5, sym_end=3 -> err_code=1, one err pulse, slot_done, no start pulses.
REQ-038 Bench SHALL check ifft_ready held 0 for 50 cycles after fft_done -> rem_start issued in the first cycle ifft_ready=1.
REQ-039 Bench SHALL check, with the macro defined, TIMEOUT_CYC=16 and fft_done never asserted -> err_code=2 after 16 cycles in WAIT_FFT, then slot_done.
REQ-040 Bench SHALL check reset asserted during WAIT_REM at sym_idx=7 -> all outputs at reset values on the next cycle, and a following slot_start runs normally.
REQ-041 Bench SHALL check slot_start pulsed while busy, plus stray rem_done in WAIT_FFT -> no state change or restart observed.
